// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the two-requester memory port arbiter.
//   - arb_state_t : FSM state encoding (IDLE / ACCESS / RESP)
//   - REQ0, REQ1  : requester IDs used for the grant, the `last` record and
//                   per-requester steering of done/rdata
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// rr_select
//   Combinational two-way round-robin pick.
//   Ports:
//     req0, req1 : request levels
//     last       : ID of the requester served most recently
//     any        : at least one request is pending
//     win_id     : ID of the requester to grant (REQ0 when nothing pending)
module rr_select
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any,
  output logic win_id
);

  always_comb begin
    any    = req0 | req1;
    win_id = REQ0;
    if (req0 && req1) begin
      // On a tie the requester that was not served last time wins.
      win_id = ~last;
    end else if (req1) begin
      win_id = REQ1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one single-port word memory (combinational
//   read, write on the clock edge) between two requesters. Each request is a
//   single-word read or write: it is latched in IDLE, driven to the memory
//   for one ACCESS cycle, and completed with a one-cycle done pulse in RESP.
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-high reset
//     req*/we*/addr*/wdata*: requester command (held until matching done)
//     done*               : one-cycle completion pulse per requester
//     rdata*              : last word read on behalf of each requester
//     mem_re/mem_we       : memory read / write enables
//     mem_drive           : enable for the external bus driver (= mem_we)
//     mem_addr/mem_wdata  : latched address / write data to the memory
//     mem_rdata           : memory data bus as observed
//     busy                : FSM is not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned W  = 256,
  parameter int unsigned AW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_re,
  output logic          mem_we,
  output logic          mem_drive,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_last;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_any;
  logic          w_win_id;
  logic          w_latch;
  logic          w_mem_re;
  logic          w_mem_we;
  logic          w_done0;
  logic          w_done1;
  logic          w_busy;

  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_select u_rr_select (
    .req0   (req0),
    .req1   (req1),
    .last   (r_last),
    .any    (w_any),
    .win_id (w_win_id)
  );

  assign w_sel_we    = (w_win_id == REQ1) ? we1    : we0;
  assign w_sel_addr  = (w_win_id == REQ1) ? addr1  : addr0;
  assign w_sel_wdata = (w_win_id == REQ1) ? wdata1 : wdata0;

  // Next-state and output decode.
  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_mem_re = 1'b0;
    w_mem_we = 1'b0;
    w_done0  = 1'b0;
    w_done1  = 1'b0;
    w_busy   = (r_state != IDLE);

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_latch = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        w_mem_re = ~r_we;
        // Gated by reset so a write caught by reset never commits.
        w_mem_we = r_we & ~reset;
        w_next   = RESP;
      end
      RESP: begin
        w_done0 = (r_id == REQ0);
        w_done1 = (r_id == REQ1);
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= REQ1;
      r_id     <= REQ0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;

      if (w_latch) begin
        r_id    <= w_win_id;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end

      if (r_state == ACCESS && !r_we) begin
        if (r_id == REQ1) begin
          r_rdata1 <= mem_rdata;
        end else begin
          r_rdata0 <= mem_rdata;
        end
      end

      if (r_state == RESP) begin
        r_last <= r_id;
      end
    end
  end

  assign done0     = w_done0;
  assign done1     = w_done1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_re    = w_mem_re;
  assign mem_we    = w_mem_we;
  assign mem_drive = w_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int W  = 256;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_re, mem_we, mem_drive;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.DW(DW), .W(W), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_drive (mem_drive),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: combinational read, write on the rising edge.
  logic [DW-1:0] mem [W];
  logic          tb_clr;
  always @(posedge clock) begin
    if (tb_clr) begin
      for (int i = 0; i < W; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        id;
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl [10];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic we, input logic [15:0] rd);
    exp_t e;
    e.id = id; e.we = we; e.rdata = rd;
    sbq.push_back(e);
  endtask

  // One clock; sample #1 after the edge and retire any done via the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    chk("done_exclusive", {31'b0, done0 & done1}, 32'h0);
    if (done0 || done1) begin
      n_done++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
      end else begin
        e = sbq.pop_front();
        chk("sb_done_id", {31'b0, done1}, {31'b0, e.id});
        if (!e.we) chk("sb_rdata", {16'h0, (e.id ? rdata1 : rdata0)}, {16'h0, e.rdata});
      end
    end
  endtask

  task automatic wait_done(input logic id, input int budget, output int waited);
    logic got;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      tick();
      waited++;
      got = id ? done1 : done0;
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int waited;
    push_exp(v.id, v.we, v.id ? v.exp_r1 : v.exp_r0);
    if (v.id) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    wait_done(v.id, 10, waited);
    chk($sformatf("tbl%0d_latency", idx), waited, 2);
    req0 = 1'b0;
    req1 = 1'b0;
    chk($sformatf("tbl%0d_rdata0", idx), {16'h0, rdata0}, {16'h0, v.exp_r0});
    chk($sformatf("tbl%0d_rdata1", idx), {16'h0, rdata1}, {16'h0, v.exp_r1});
    tick();
    chk($sformatf("tbl%0d_idle", idx), {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int k;
    int start;
    int dcnt;
    int dt [3];

    tbl[0] = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 16'h5A5A, 16'h0000, 16'hBEEF};
    tbl[3] = '{1'b0, 1'b0, 8'h33, 16'h0000, 16'h5A5A, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b1, 8'h20, 16'hCAFE, 16'h5A5A, 16'hBEEF};
    tbl[5] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h5A5A, 16'hCAFE};
    tbl[6] = '{1'b0, 1'b1, 8'hFF, 16'h0001, 16'h5A5A, 16'hCAFE};
    tbl[7] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0001, 16'hCAFE};
    tbl[8] = '{1'b1, 1'b1, 8'h00, 16'hFFFF, 16'h0001, 16'hCAFE};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'hFFFF};

    // Reset held two cycles with both requests asserted.
    tb_clr = 1'b1;
    reset  = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h05; addr1 = 8'h05; wdata0 = '0; wdata1 = '0;
    tick();
    tick();
    chk("rst_ctrl", {26'h0, done0, done1, mem_re, mem_we, mem_drive, busy}, 32'h0);
    chk("rst_addr_wdata", {8'h0, mem_addr, mem_wdata}, 32'h0);
    chk("rst_rdata", {rdata0, rdata1}, 32'h0);
    tb_clr = 1'b0;
    reset  = 1'b0;

    // Requester 0 wins the first tie; held requester 1 is served next.
    push_exp(1'b0, 1'b0, 16'h0000);
    push_exp(1'b1, 1'b0, 16'h0000);
    wait_done(1'b0, 10, waited);
    chk("first_tie_latency", waited, 2);
    req0 = 1'b0;
    wait_done(1'b1, 10, waited);
    chk("held_req1_latency", waited, 3);
    req1 = 1'b0;
    tick();

    // Single-requester transactions from the vector table.
    for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

    // Fairness: both requesters write continuously for 12 cycles.
    push_exp(1'b0, 1'b1, 16'h0);
    push_exp(1'b1, 1'b1, 16'h0);
    push_exp(1'b0, 1'b1, 16'h0);
    push_exp(1'b1, 1'b1, 16'h0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h41; wdata1 = 16'h2222;
    n_done = 0;
    for (k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("fair_we_c%0d", k), {31'b0, mem_we}, (k % 3 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("fair_drive_c%0d", k), {31'b0, mem_drive}, (k % 3 == 1) ? 32'h1 : 32'h0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("fair_done_count", n_done, 4);
    chk("fair_sb_empty", sbq.size(), 0);
    tick();
    chk("fair_idle", {31'b0, busy}, 32'h0);
    chk("fair_mem40", {16'h0, mem[8'h40]}, 32'h1111);
    chk("fair_mem41", {16'h0, mem[8'h41]}, 32'h2222);

    // Dropped request: req1 read latched, then released during ACCESS.
    push_exp(1'b1, 1'b0, 16'h5A5A);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h33;
    tick();
    chk("drop_access_re", {31'b0, mem_re}, 32'h1);
    req1 = 1'b0;
    tick();
    chk("drop_done1", {31'b0, done1}, 32'h1);
    chk("drop_rdata1", {16'h0, rdata1}, 32'h5A5A);
    tick();

    // Back-to-back reads by requester 0 at 00, 01, 02.
    push_exp(1'b0, 1'b0, 16'hFFFF);
    push_exp(1'b0, 1'b0, 16'h0000);
    push_exp(1'b0, 1'b0, 16'h0000);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    start = cyc;
    dcnt = 0;
    for (int i = 0; i < 3; i++) dt[i] = -1;
    for (int t = 0; t < 20 && dcnt < 3; t++) begin
      tick();
      if (done0) begin
        dt[dcnt] = cyc - start;
        dcnt++;
        addr0 = addr0 + 8'h01;
        if (dcnt == 3) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    chk("b2b_done_a", dt[0], 2);
    chk("b2b_done_b", dt[1], 5);
    chk("b2b_done_c", dt[2], 8);
    tick();

    // Reset arriving during the ACCESS cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'h1234;
    tick();
    chk("rstacc_we_pre", {31'b0, mem_we}, 32'h1);
    req0  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstacc_we_gated", {31'b0, mem_we}, 32'h0);
    tick();
    chk("rstacc_idle", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rstacc_no_done_a", {30'h0, done0, done1}, 32'h0);
    tick();
    chk("rstacc_no_done_b", {30'h0, done0, done1}, 32'h0);
    chk("rstacc_mem20", {16'h0, mem[8'h20]}, 32'hCAFE);
    run_txn(10, '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000, 16'hCAFE});
    chk("final_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
